board_scorer: RTL and testbench

//   Downstream of the flipper. After a move completes, scans every gameboard RAM cell

---
 rtl/board_scorer.sv | 148 ++++++++++++++
 tb/tb_board_scorer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/board_scorer.sv
// Scans every gameboard RAM cell through the memorymux read port and tallies
// player-0, player-1 and empty cells, then publishes counts and game flags.
module board_scorer #(
    parameter int N_CELLS = 64,
    parameter int ADDR_W  = 7,
    parameter int CNT_W   = 7,
    parameter int RD_LAT  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              wren_o,
    output logic              ctrl_mem,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count_p0,
    output logic [CNT_W-1:0]  count_p1,
    output logic [CNT_W-1:0]  count_empty,
    output logic              board_full,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          drain_q;
    logic [RD_LAT-1:0]   vld_q;
    logic                ctrl_q, busy_q, done_q;
    logic [CNT_W-1:0]    acc_p0_q, acc_p1_q, acc_empty_q;
    logic [CNT_W-1:0]    acc_p0_d, acc_p1_d, acc_empty_d;
    logic                acc_err_q, acc_err_d;
    logic [CNT_W-1:0]    cnt_p0_q, cnt_p1_q, cnt_empty_q;
    logic                full_q, err_q;
    logic [1:0]          winner_q;
    logic                sample;

    // The oldest tap of the valid pipe lines up with the data of its address.
    assign sample = vld_q[RD_LAT-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_p0_d    = acc_p0_q;
        acc_p1_d    = acc_p1_q;
        acc_empty_d = acc_empty_q;
        acc_err_d   = acc_err_q;
        if (sample) begin
            unique case (data_in)
                2'b00: acc_empty_d = acc_empty_q + CNT_W'(1);
                2'b01: acc_p0_d    = acc_p0_q + CNT_W'(1);
                2'b10: acc_p1_d    = acc_p1_q + CNT_W'(1);
                default: acc_err_d = 1'b1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the values from before the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            drain_q     <= '0;
            vld_q       <= '0;
            ctrl_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_p0_q    <= '0;
            acc_p1_q    <= '0;
            acc_empty_q <= '0;
            acc_err_q   <= 1'b0;
            cnt_p0_q    <= '0;
            cnt_p1_q    <= '0;
            cnt_empty_q <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            vld_q       <= (vld_q << 1) | RD_LAT'(state_q == SCAN);
            acc_p0_q    <= acc_p0_d;
            acc_p1_q    <= acc_p1_d;
            acc_empty_q <= acc_empty_d;
            acc_err_q   <= acc_err_d;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_p0_q    <= '0;
                        acc_p1_q    <= '0;
                        acc_empty_q <= '0;
                        acc_err_q   <= 1'b0;
                        addr_q      <= '0;
                        vld_q       <= '0;
                        ctrl_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (addr_q == ADDR_W'(N_CELLS - 1)) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == 2'(RD_LAT - 1)) state_q <= FIN;
                    else                           drain_q <= drain_q + 2'd1;
                end
                FIN: begin
                    // Accumulators are complete here; publish them in one step.
                    cnt_p0_q    <= acc_p0_q;
                    cnt_p1_q    <= acc_p1_q;
                    cnt_empty_q <= acc_empty_q;
                    full_q      <= (acc_empty_q == '0);
                    err_q       <= acc_err_q;
                    winner_q    <= (acc_p0_q > acc_p1_q) ? 2'b01 :
                                   (acc_p1_q > acc_p0_q) ? 2'b10 : 2'b00;
                    done_q      <= 1'b1;
                    ctrl_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    addr_q      <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_out    = addr_q;
    assign wren_o      = 1'b0;
    assign ctrl_mem    = ctrl_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign count_p0    = cnt_p0_q;
    assign count_p1    = cnt_p1_q;
    assign count_empty = cnt_empty_q;
    assign board_full  = full_q;
    assign game_over   = full_q | (cnt_p0_q == '0) | (cnt_p1_q == '0);
    assign winner      = winner_q;
    assign err         = err_q;

endmodule

// File: tb/tb_board_scorer.sv
// Directed bench for board_scorer: a RD_LAT=2 and a RD_LAT=1 instance read one
// shared board model through their own read-latency pipelines.
module tb_board_scorer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mem [128];

    logic [1:0] d0, d1, pipe0a, pipe0b, pipe1a;
    logic [6:0] addr0, addr1;
    logic       wren0, ctrl0, busy0, done0, full0, go0, err0;
    logic       wren1, ctrl1, busy1, done1, full1, go1, err1;
    logic [6:0] p0_0, p1_0, em_0, p0_1, p1_1, em_1;
    logic [1:0] win0, win1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    board_scorer #(.RD_LAT(2)) dut (
        .clock(clock), .reset(reset), .start(start), .data_in(d0),
        .addr_out(addr0), .wren_o(wren0), .ctrl_mem(ctrl0), .busy(busy0), .done(done0),
        .count_p0(p0_0), .count_p1(p1_0), .count_empty(em_0), .board_full(full0),
        .game_over(go0), .winner(win0), .err(err0)
    );

    board_scorer #(.RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .data_in(d1),
        .addr_out(addr1), .wren_o(wren1), .ctrl_mem(ctrl1), .busy(busy1), .done(done1),
        .count_p0(p0_1), .count_p1(p1_1), .count_empty(em_1), .board_full(full1),
        .game_over(go1), .winner(win1), .err(err1)
    );

    always @(posedge clock) begin
        pipe0a <= mem[addr0];
        pipe0b <= pipe0a;
        pipe1a <= mem[addr1];
    end
    assign d0 = pipe0b;
    assign d1 = pipe1a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [1:0] v);
        for (int i = 0; i < 128; i++) mem[i] = v;
    endtask

    task automatic initial_board();
        fill(2'b00);
        mem[27] = 2'b01; mem[36] = 2'b01;
        mem[28] = 2'b10; mem[35] = 2'b10;
    endtask

    // Pulses start, optionally re-pulses it at cycle restart_at, and watches 90 cycles.
    task automatic run_scan(input int restart_at, output int lat0, output int lat1,
                            output int npulse, output logic busy1c, output int addr10);
        lat0 = -1; lat1 = -1; npulse = 0; busy1c = 1'b0; addr10 = -1;
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            if (c == restart_at) start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            if (c == 1)  busy1c = busy0 & ctrl0;
            if (c == 10) addr10 = int'(addr0);
            if (done0) begin
                npulse++;
                if (lat0 < 0) lat0 = c;
            end
            if (done1 && lat1 < 0) lat1 = c;
        end
    endtask

    task automatic check_res(input string t, input int p0, input int p1, input int em,
                             input logic full, input logic go, input logic [1:0] win,
                             input logic er);
        check({t, "_p0"},    p0_0, p0);
        check({t, "_p1"},    p1_0, p1);
        check({t, "_empty"}, em_0, em);
        check({t, "_full"},  full0, full);
        check({t, "_over"},  go0, go);
        check({t, "_win"},   win0, win);
        check({t, "_err"},   err0, er);
        check({t, "_idle"},  {busy0, ctrl0, wren0}, 3'b000);
    endtask

    initial begin
        int   l0, l1, np, a10;
        logic b1;

        initial_board();
        repeat (3) @(posedge clock);
        #1;
        check("rst_counts", {p0_0, p1_0, em_0}, 21'd0);
        check("rst_flags",  {full0, err0, win0, done0, busy0, ctrl0}, 7'd0);
        check("rst_over",   go0, 1'b1);
        check("rst_addr",   addr0, 7'd0);
        @(negedge clock) reset = 1'b0;

        // 1: initial board
        run_scan(0, l0, l1, np, b1, a10);
        check("t1_lat", l0, 67);
        check("t1_pulses", np, 1);
        check("t1_busy", b1, 1'b1);
        check("t1_addr10", a10, 10);
        check_res("t1", 2, 2, 60, 1'b0, 1'b0, 2'b00, 1'b0);

        // 2: all player 0
        fill(2'b01);
        run_scan(0, l0, l1, np, b1, a10);
        check_res("t2", 64, 0, 0, 1'b1, 1'b1, 2'b01, 1'b0);

        // 3: 40 player-1 cells, rest empty
        fill(2'b00);
        for (int i = 0; i < 40; i++) mem[i] = 2'b10;
        run_scan(0, l0, l1, np, b1, a10);
        check_res("t3", 0, 40, 24, 1'b0, 1'b1, 2'b10, 1'b0);

        // 4: reset at scan cycle 30, then a fresh scan
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (29) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        check("t4_ctrl", {ctrl0, busy0, done0}, 3'b000);
        check("t4_counts", {p0_0, p1_0, em_0}, 21'd0);
        check("t4_over", go0, 1'b1);
        @(negedge clock) reset = 1'b0;
        np = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clock);
            #1 if (done0) np++;
        end
        check("t4_nodone", np, 0);
        initial_board();
        run_scan(0, l0, l1, np, b1, a10);
        check("t4_lat", l0, 67);
        check_res("t4", 2, 2, 60, 1'b0, 1'b0, 2'b00, 1'b0);

        // 5: start re-pulsed mid-scan is ignored
        fill(2'b01);
        run_scan(0, l0, l1, np, b1, a10);
        initial_board();
        run_scan(20, l0, l1, np, b1, a10);
        check("t5_pulses", np, 1);
        check("t5_lat", l0, 67);
        check_res("t5", 2, 2, 60, 1'b0, 1'b0, 2'b00, 1'b0);

        // 6: illegal cell, both read latencies
        mem[5] = 2'b11;
        run_scan(0, l0, l1, np, b1, a10);
        check_res("t6", 2, 2, 59, 1'b0, 1'b0, 2'b00, 1'b1);
        check("t6_lat1", l1, 66);
        check("t6_r1_counts", {p0_1, p1_1, em_1}, {7'd2, 7'd2, 7'd59});
        check("t6_r1_err", {err1, win1, go1}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
